// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
package instruction_fetch_controller_pkg;

    // Controller state encoding
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // One fetch-queue entry: returned instruction together with its PC
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fq_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    // True when a byte address lies below 4*mem_words; done in 34 bits so
    // large memory sizes cannot wrap the limit.
    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned mem_words);
        logic [33:0] limit;
        limit = {mem_words, 2'b00};
        return ({2'b00, pc} < limit);
    endfunction

endpackage

// File: rtl/instruction_fetch_controller_fetch_queue.sv
// Two-entry fetch FIFO. Slot 0 is always the head; empty slots hold zero so
// the head outputs read as zero when the queue is empty.
module instruction_fetch_controller_fetch_queue
    import instruction_fetch_controller_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [63:0] i_din,
    output logic [1:0]  o_count,
    output logic        o_valid,
    output logic [63:0] o_head
);

    fq_entry_t   r_slot [2];
    logic [1:0]  r_count;

    fq_entry_t   w_slot_next [2];
    logic [1:0]  w_count_after_pop;
    logic [1:0]  w_count_next;
    logic        w_pop;
    logic        w_push;

    // Pop only a valid head; push is accepted when a slot is (or becomes) free
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count < 2'd2) || w_pop);

    // Next slot contents: shift on pop, then write the new entry behind the
    // surviving entries
    always_comb begin
        w_slot_next[0]    = r_slot[0];
        w_slot_next[1]    = r_slot[1];
        w_count_after_pop = r_count;
        if (w_pop) begin
            w_slot_next[0]    = r_slot[1];
            w_slot_next[1]    = '0;
            w_count_after_pop = r_count - 2'd1;
        end
        w_count_next = w_count_after_pop;
        if (w_push) begin
            w_slot_next[w_count_after_pop[0]] = fq_entry_t'(i_din);
            w_count_next = w_count_after_pop + 2'd1;
        end
    end

    // Slot registers; reset and flush both empty the queue, flush beats push
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge i_clk) begin
                if (i_srst || i_flush) begin
                    r_slot[gi] <= '0;
                end else begin
                    r_slot[gi] <= w_slot_next[gi];
                end
            end
        end
    endgenerate

    // Occupancy counter
    always_ff @(posedge i_clk) begin
        if (i_srst || i_flush) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_slot[0];

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the combinational-read
// instruction memory and feeds a 2-entry queue towards IF/ID.
module instruction_fetch_controller
    import instruction_fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic        OutReady,
    output logic        OutValid,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4,
    output logic        Fault
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_fault;

    logic [31:0]  w_target;
    logic         w_pc_ok;
    logic         w_fire;
    logic [1:0]   w_count;
    logic         w_valid;
    logic [63:0]  w_head;
    fq_entry_t    w_head_entry;
    fq_entry_t    w_push_entry;

    assign w_target = {RedirectTarget[31:2], 2'b00};
    assign w_pc_ok  = pc_in_range(r_pc, MEM_WORDS);

    // Fetch whenever a slot is free, or the full queue is draining this cycle
    assign w_fire = (r_state == RUN) && w_pc_ok && !Redirect &&
                    ((w_count < 2'd2) || OutReady);

    assign w_push_entry.instruction = Instruction;
    assign w_push_entry.pc          = r_pc;

    instruction_fetch_controller_fetch_queue u_fetch_queue (
        .i_clk   (Clk),
        .i_srst  (Rst),
        .i_flush (Redirect),
        .i_push  (w_fire),
        .i_pop   (OutReady),
        .i_din   (w_push_entry),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_head  (w_head)
    );

    // PC / RUN-HALT state machine; reset beats redirect beats normal fetch
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc    <= RESET_PC;
            r_state <= RUN;
            r_fault <= 1'b0;
        end else if (Redirect) begin
            r_pc <= w_target;
            if (pc_in_range(w_target, MEM_WORDS)) begin
                r_state <= RUN;
                r_fault <= 1'b0;
            end else begin
                r_state <= HALT;
                r_fault <= 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_pc_ok) begin
                        r_state <= HALT;
                        r_fault <= 1'b1;
                    end else if (w_fire) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                HALT: begin
                    r_pc <= r_pc;
                end
                default: begin
                    r_state <= HALT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign w_head_entry   = fq_entry_t'(w_head);
    assign Address        = r_pc;
    assign Fault          = r_fault;
    assign OutValid       = w_valid;
    assign OutInstruction = w_head_entry.instruction;
    assign OutPC          = w_head_entry.pc;
    assign OutPCPlus4     = w_valid ? (w_head_entry.pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instruction_fetch_controller;

    localparam int unsigned TB_MEM_WORDS = 32;
    localparam logic [31:0] TB_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] LIMIT        = 32'(4 * TB_MEM_WORDS);

    logic        Clk;
    logic        Rst;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] OutInstruction;
    logic [31:0] OutPC;
    logic [31:0] OutPCPlus4;
    logic        Fault;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [63:0] m_q[$];
    logic [31:0] m_pc   = TB_RESET_PC;
    bit          m_halt = 1'b0;

    instruction_fetch_controller #(
        .RESET_PC  (TB_RESET_PC),
        .MEM_WORDS (TB_MEM_WORDS)
    ) u_dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Address        (Address),
        .Instruction    (Instruction),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .OutReady       (OutReady),
        .OutValid       (OutValid),
        .OutInstruction (OutInstruction),
        .OutPC          (OutPC),
        .OutPCPlus4     (OutPCPlus4),
        .Fault          (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Combinational instruction memory: word n holds 0x1000_0000 + n
    assign Instruction = mem_word(Address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock edge of the reference model
    task automatic model_step(input logic rst, input logic redir, input logic [31:0] tgt,
                              input logic ready);
        if (rst) begin
            m_q.delete();
            m_pc   = TB_RESET_PC;
            m_halt = 1'b0;
        end else begin
            if (ready && m_q.size() > 0) void'(m_q.pop_front());
            if (redir) begin
                m_q.delete();
                m_pc   = {tgt[31:2], 2'b00};
                m_halt = !(m_pc < LIMIT);
            end else if (!m_halt) begin
                if (m_pc >= LIMIT) begin
                    m_halt = 1'b1;
                end else if (m_q.size() < 2) begin
                    m_q.push_back({mem_word(m_pc), m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] head;
        bit          v;
        v    = (m_q.size() != 0);
        head = v ? m_q[0] : 64'd0;
        check_eq("addr",  Address,        m_pc);
        check_eq("valid", 32'(OutValid),  32'(v));
        check_eq("instr", OutInstruction, head[63:32]);
        check_eq("pc",    OutPC,          head[31:0]);
        check_eq("pc4",   OutPCPlus4,     v ? head[31:0] + 32'd4 : 32'd0);
        check_eq("fault", 32'(Fault),     32'(m_halt));
    endtask

    // Apply inputs for one cycle, advance DUT and model, then compare
    task automatic cycle(input logic rst, input logic redir, input logic [31:0] tgt,
                         input logic ready);
        Rst            = rst;
        Redirect       = redir;
        RedirectTarget = tgt;
        OutReady       = ready;
        #1;
        if (OutValid && OutReady && !Rst)
            $display("xfer pc=%08h instr=%08h redir=%0b", OutPC, OutInstruction, Redirect);
        @(posedge Clk);
        model_step(rst, redir, tgt, ready);
        @(negedge Clk);
        compare_all();
    endtask

    initial begin
        Rst            = 1'b1;
        Redirect       = 1'b0;
        RedirectTarget = 32'd0;
        OutReady       = 1'b0;
        @(negedge Clk);

        // Reset state
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check_eq("rst_addr",  Address,           32'h0);
        check_eq("rst_valid", 32'(OutValid),     32'd0);
        check_eq("rst_instr", OutInstruction,    32'h0);
        check_eq("rst_fault", 32'(Fault),        32'd0);

        // Free run: first entry one cycle after reset release
        cycle(0, 0, 0, 1);
        check_eq("run_valid", 32'(OutValid),     32'd1);
        check_eq("run_pc0",   OutPC,             32'h0);
        check_eq("run_ins0",  OutInstruction,    32'h1000_0000);
        for (int k = 1; k < 4; k++) begin
            cycle(0, 0, 0, 1);
            check_eq("run_pck", OutPC,           32'(4 * k));
        end

        // Backpressure from reset
        cycle(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
        check_eq("bp_addr",   Address,           32'h8);
        check_eq("bp_head",   OutPC,             32'h0);
        cycle(0, 0, 0, 1);
        check_eq("bp_head4",  OutPC,             32'h4);
        cycle(0, 0, 0, 1);
        check_eq("bp_head8",  OutPC,             32'h8);

        // Redirect while full
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h0000_0043, 0);
        check_eq("rd_valid",  32'(OutValid),     32'd0);
        check_eq("rd_addr",   Address,           32'h40);
        cycle(0, 0, 0, 0);
        check_eq("rd_pc",     OutPC,             32'h40);
        check_eq("rd_pc4",    OutPCPlus4,        32'h44);

        // Run off the end of memory
        cycle(0, 1, LIMIT - 32'd16, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 1);
            check_eq("ro_pc",  OutPC,            LIMIT - 32'd16 + 32'(4 * k));
        end
        check_eq("ro_nofault", 32'(Fault),       32'd0);
        cycle(0, 0, 0, 1);
        check_eq("ro_fault",  32'(Fault),        32'd1);
        check_eq("ro_addr",   Address,           LIMIT);
        cycle(0, 0, 0, 1);
        check_eq("ro_hold",   Address,           LIMIT);
        check_eq("ro_empty",  32'(OutValid),     32'd0);

        // Redirect out of HALT
        cycle(0, 1, 32'h0, 1);
        check_eq("hr_fault",  32'(Fault),        32'd0);
        check_eq("hr_addr",   Address,           32'h0);
        cycle(0, 0, 0, 1);
        check_eq("hr_pc",     OutPC,             32'h0);

        // Reset together with redirect
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 1, 32'h20, 1);
        check_eq("rr_addr",   Address,           TB_RESET_PC);
        check_eq("rr_valid",  32'(OutValid),     32'd0);
        check_eq("rr_fault",  32'(Fault),        32'd0);
        cycle(0, 0, 0, 1);
        check_eq("rr_pc",     OutPC,             TB_RESET_PC);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            logic        r_rst;
            logic        r_redir;
            logic        r_ready;
            logic [31:0] r_tgt;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                r_tgt = 32'($urandom_range(0, int'(LIMIT) + 16));
            else
                r_tgt = $urandom;
            cycle(r_rst, r_redir, r_tgt, r_ready);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequences the combinational-read instruction memory for the MIPS pipeline. Owns the program counter, drives the memory word address, and captures each returned instruction with its PC into a 2-entry fetch queue. Presents fetched instructions to the IF/ID stage over a valid/ready handshake and services branch/jump redirects with a queue flush. Sits between the instruction memory and the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; word-aligned.
- MEM_WORDS, 1024: number of valid instruction words; byte addresses at or above 4*MEM_WORDS are out of range.
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Address  out  32  byte address to instruction memory; always equals PC.
- Instruction  in  32  memory read data for Address; valid in the same cycle.
- Redirect  in  1  branch/jump taken; flush queue and load RedirectTarget.
- RedirectTarget  in  32  new PC; bits [1:0] are ignored and forced to 0.
- OutReady  in  1  IF/ID accepts the head entry this cycle.
- OutValid  out  1  queue head is valid.
- OutInstruction  out  32  head instruction; 0 when empty.
- OutPC  out  32  head PC; 0 when empty.
- OutPCPlus4  out  32  OutPC+4; 0 when empty.
- Fault  out  1  PC is out of range; fetching is halted.

## Operation
- States: RUN and HALT. Reset enters RUN with PC=RESET_PC, queue empty, OutValid=0, all Out* data=0, Fault=0.
- Fetch in RUN: fire = (count<2) or (count==2 and OutReady). When fire is high, enqueue {Instruction, PC} and set PC <= PC+4. Arithmetic is 32-bit modulo; no carry out.
- Dequeue: OutValid and OutReady pop the head. Enqueue and dequeue can happen in the same cycle, and count is unchanged.
- Range check: if PC >= 4*MEM_WORDS in RUN, there is no enqueue. The controller goes to HALT and Fault=1. Entries already queued still drain normally.
- HALT: PC holds and nothing is enqueued. Only Redirect or Rst leaves HALT.
- Redirect has the highest priority:
  - The queue empties at the next edge. Any head being accepted that cycle is still consumed by IF/ID.
  - Nothing is enqueued in the redirect cycle.
  - PC <= {RedirectTarget[31:2],2'b00}.
  - Next state is RUN with Fault=0 if the target is in range, otherwise HALT with Fault=1.
- Rst overrides Redirect and everything else.

## Timing
- Memory read is combinational. The fetch decision and the enqueue happen in the cycle Address=PC is presented.
- Latency:
  - PC presented to entry visible on OutValid/OutInstruction: 1 cycle (registered queue).
  - Redirect to first fetch at the target: 1 cycle.
  - Redirect to first OutValid at the target: 2 cycles.
- Steady-state throughput is one instruction per cycle when OutReady=1.
- Out* outputs come directly from queue registers. OutReady feeds only the fire/pop logic. There is no combinational path from Instruction to Out*.
- Fault goes high the cycle after PC first equals an out-of-range address, and stays high until the next Redirect or Rst.

## Structure
- Shared package holds:
  - the state encoding (RUN=1'b0, HALT=1'b1);
  - the queue-entry layout (instruction[31:0], pc[31:0]);
  - the constants RESET_PC and MEM_WORDS defaults.
- One sub-module is natural: fetch_queue, a 2-entry FIFO with push, pop, flush, count and head outputs. Flush has priority over push. Push and pop on a full queue are both legal.
- The PC register, range check and state machine live in the top module.

## Test plan
- Reset then free run with OutReady=1 and memory word n = 32'h1000_0000+n: OutValid first rises 1 cycle after Rst falls, with OutPC=0 and OutInstruction=32'h1000_0000. After that, one entry per cycle with consecutive PCs.
- Backpressure: hold OutReady=0 for 5 cycles from reset. Queue fills with PC 0 and PC 4. Address holds at 8 and the head stays at PC 0. Releasing OutReady resumes 0, 4, 8 with no drops or duplicates.
- Redirect to 32'h0000_0043 while the queue is full: the next cycle has OutValid=0 and Address=32'h40. One cycle later the head is PC 32'h40 with PCPlus4=32'h44.
- Run-off with MEM_WORDS=4: PCs 0 through 12 are delivered. At PC 16, Fault=1 the next cycle, Address holds at 16, and no further entries are enqueued.
- Redirect to 0 while in HALT clears Fault and resumes from PC 0.
- Rst asserted together with Redirect mid-stream: PC returns to RESET_PC, the queue is empty and Fault=0. The target is ignored.
